// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one external combinational ALU.
// One operation in flight: IDLE (accept) -> EXEC (capture ALU) -> RESP (hold until taken).
module alu_share_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   // Request handshake: an operation is accepted in the cycle where reqN_valid
   // and reqN_ready are both high; reqN_ready only rises in IDLE outside reset.
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             gnt_q, gnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   logic             any_valid;
   logic             pick;
   logic             rsp_fire;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110: op_legal = 1'b1;
         default:                                              op_legal = 1'b0;
      endcase
   endfunction

   // Tie goes to whoever was not served last; a lone requester always wins.
   assign any_valid = req0_valid | req1_valid;
   assign pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
   assign rsp_fire  = gnt_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      zero_d     = zero_q;
      err_d      = err_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_valid && !rst) begin
               req0_ready = ~pick;
               req1_ready = pick;
               gnt_d      = pick;
               op_d       = pick ? req1_op : req0_op;
               a_d        = pick ? req1_a  : req0_a;
               b_d        = pick ? req1_b  : req0_b;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            // Illegal opcodes never expose whatever the ALU happens to produce.
            if (op_legal(op_q)) begin
               res_d  = alu_result;
               zero_d = alu_zero;
               err_d  = 1'b0;
            end else begin
               res_d  = '0;
               zero_d = 1'b1;
               err_d  = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            rsp0_valid = ~gnt_q;
            rsp1_valid = gnt_q;
            if (rsp_fire) begin
               last_d  = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign alu_op      = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign rsp_result  = res_q;
   assign rsp_zero    = zero_q;
   assign rsp_err     = err_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: models the shared ALU, scoreboards responses per accept.
module tb_alu_share_ctrl;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 0, req1_valid = 0;
   logic          req0_ready, req1_ready;
   logic [3:0]    req0_op = 0, req1_op = 0;
   logic [W-1:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0]    alu_op;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic          alu_zero;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready = 0, rsp1_ready = 0;
   logic [W-1:0]  rsp_result;
   logic          rsp_zero, rsp_err, busy;
   logic [1:0]    dbg_state;

   int            checks = 0;
   int            errors = 0;
   bit            tb_last = 1'b1;
   logic [W+1:0]  exp_q[$];
   logic [3:0]    legal_ops [6] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110};

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   // External ALU; unknown opcodes return junk the controller must suppress.
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0100: alu_result = alu_a - alu_b;
         4'b0001: alu_result = alu_a & alu_b;
         4'b0101: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a ^ alu_b;
         4'b0110: alu_result = alu_b;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   function automatic logic [W+1:0] exp_rsp(input logic [3:0] op, input logic [W-1:0] a, b);
      logic [W-1:0] r;
      r = '0;
      case (op)
         4'b0000: r = a + b;
         4'b0100: r = a - b;
         4'b0001: r = a & b;
         4'b0101: r = a | b;
         4'b0010: r = a ^ b;
         4'b0110: r = b;
         default: return {1'b1, 1'b1, {W{1'b0}}};
      endcase
      return {1'b0, (r == '0), r};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (rsp0_valid && rsp1_valid) begin
            errors++;
            $display("FAIL double_rsp: rsp0_valid=%b rsp1_valid=%b, required not both", rsp0_valid, rsp1_valid);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, dbg_state} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b rdy=%b%b vld=%b%b st=%0d, required all 0",
                  busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, dbg_state);
      end
      checks++;
      if ({alu_op, alu_a, alu_b, rsp_result, rsp_zero, rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_data: op=%h a=%h b=%h res=%h z=%b e=%b, required 0",
                  alu_op, alu_a, alu_b, rsp_result, rsp_zero, rsp_err);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      tb_last = 1'b1;
      exp_q.delete();
      @(negedge clk); #1;
   endtask

   // Starts and ends at a negedge(+1) with the DUT in IDLE.
   task automatic run_txn(input bit v0, input bit v1,
                          input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int delay);
      bit           g;
      int           n;
      logic [W+1:0] e;
      logic         gv, ov;
      g = (v0 && v1) ? ~tb_last : v1;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      checks++;
      if (req0_ready !== !g || req1_ready !== g || busy !== 1'b0) begin
         errors++;
         $display("FAIL accept: rdy0=%b rdy1=%b busy=%b, required rdy0=%b rdy1=%b busy=0",
                  req0_ready, req1_ready, busy, !g, g);
      end
      exp_q.push_back(g ? exp_rsp(op1, a1, b1) : exp_rsp(op0, a0, b0));

      @(negedge clk);
      // Scramble requests while busy; none of it may reach the in-flight op.
      req0_valid = 1'b1; req0_op = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
      req1_valid = 1'b1; req1_op = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
      #1;
      checks++;
      if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL exec: busy=%b rdy=%b%b vld=%b%b, required busy=1 rest 0",
                  busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
      end

      @(negedge clk); #1;
      gv = g ? rsp1_valid : rsp0_valid;
      checks++;
      if (gv !== 1'b1) begin
         errors++;
         $display("FAIL rsp_latency: rsp%0d_valid=%b at T+2, required 1", g, gv);
         n = 0;
         while (!(g ? rsp1_valid : rsp0_valid) && n < 8) begin
            @(negedge clk); #1; n++;
         end
         if (!(g ? rsp1_valid : rsp0_valid)) begin
            errors++;
            $display("FAIL rsp_timeout: rsp%0d_valid never rose, required 1", g);
            void'(exp_q.pop_front());
            req0_valid = 1'b0; req1_valid = 1'b0;
            test_reset();
            return;
         end
      end

      e = exp_q[0];
      for (int i = 0; i < delay; i++) begin
         rsp0_ready = g;  // ready on the other port only: must be ignored
         rsp1_ready = !g;
         #1;
         gv = g ? rsp1_valid : rsp0_valid;
         ov = g ? rsp0_valid : rsp1_valid;
         checks++;
         if (gv !== 1'b1 || ov !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
             {rsp_err, rsp_zero, rsp_result} !== e) begin
            errors++;
            $display("FAIL rsp_hold: vld=%b other=%b busy=%b rdy=%b%b e/z/r=%b/%b/%h, required 1 0 1 00 %b/%b/%h",
                     gv, ov, busy, req0_ready, req1_ready, rsp_err, rsp_zero, rsp_result, e[W+1], e[W], e[W-1:0]);
         end
         @(negedge clk);
      end

      rsp0_ready = !g; rsp1_ready = g;
      #1;
      e = exp_q.pop_front();
      gv = g ? rsp1_valid : rsp0_valid;
      checks++;
      if (gv !== 1'b1 || {rsp_err, rsp_zero, rsp_result} !== e) begin
         errors++;
         $display("FAIL rsp_payload: id=%0d vld=%b e/z/r=%b/%b/%h, required 1 %b/%b/%h",
                  g, gv, rsp_err, rsp_zero, rsp_result, e[W+1], e[W], e[W-1:0]);
      end

      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rsp_done: vld=%b%b busy=%b, required 000", rsp0_valid, rsp1_valid, busy);
      end
      tb_last = g;
   endtask

   task automatic test_basic();
      run_txn(1, 0, 4'b0000, 5, 7, 4'b0000, 0, 0, 0);
   endtask

   task automatic test_round_robin();
      test_reset();
      for (int i = 0; i < 4; i++) begin
         run_txn(1, 1, legal_ops[$urandom_range(0, 5)], $urandom, $urandom,
                       legal_ops[$urandom_range(0, 5)], $urandom, $urandom, 0);
         checks++;
         if (tb_last !== i[0]) begin
            errors++;
            $display("FAIL rr_order: op %0d granted %0d, required %0d", i, tb_last, i[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      run_txn(0, 1, 4'b0000, 0, 0, 4'b0100, 9, 9, 5);
   endtask

   task automatic test_illegal();
      run_txn(1, 0, 4'b1111, 32'h1234, 32'h5678, 4'b0000, 0, 0, 1);
      run_txn(1, 1, 4'b0000, 1, 2, 4'b0001, 3, 6, 0);
      checks++;
      if (tb_last !== 1'b1) begin
         errors++;
         $display("FAIL illegal_ptr: tie granted %0d, required 1", tb_last);
      end
   endtask

   task automatic test_boundary();
      run_txn(1, 0, 4'b0110, 1, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
      run_txn(0, 1, 4'b0000, 0, 0, 4'b0000, 32'hFFFF_FFFF, 1, 2);
      run_txn(1, 0, 4'b0100, 0, 1, 4'b0000, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         logic [3:0] o0, o1;
         o0 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : legal_ops[$urandom_range(0, 5)];
         o1 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : legal_ops[$urandom_range(0, 5)];
         case ($urandom_range(0, 2))
            0:       run_txn(1, 0, o0, $urandom, $urandom, o1, $urandom, $urandom, $urandom_range(0, 3));
            1:       run_txn(0, 1, o0, $urandom, $urandom, o1, $urandom, $urandom, $urandom_range(0, 3));
            default: run_txn(1, 1, o0, $urandom, $urandom, o1, $urandom, $urandom, $urandom_range(0, 3));
         endcase
      end
   endtask

   task automatic test_reset_resp();
      run_txn(1, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 3; req0_b = 4;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b1) begin
         errors++;
         $display("FAIL rr_pre_reset: rsp0_valid=%b, required 1", rsp0_valid);
      end
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready, rsp_result, rsp_zero, rsp_err, alu_op, alu_a, alu_b} !== '0) begin
         errors++;
         $display("FAIL reset_in_resp: vld=%b%b busy=%b rdy=%b%b res=%h z=%b e=%b op=%h a=%h b=%h, required 0",
                  rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready, rsp_result, rsp_zero, rsp_err, alu_op, alu_a, alu_b);
      end
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tb_last = 1'b1;
      exp_q.delete();
      @(negedge clk); #1;
      run_txn(1, 1, 4'b0010, 32'hF0F0, 32'h0FF0, 4'b0000, 1, 1, 0);
      checks++;
      if (tb_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_tie: granted %0d, required 0", tb_last);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_backpressure();
      test_illegal();
      test_boundary();
      test_back_to_back();
      test_reset_resp();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester N's operation accepted this cycle.
REQ-006 SHALL have ports: req0_op / req1_op  input  4  ALU opcode; req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-007 SHALL have ports: alu_op  output  4; alu_a, alu_b  output  WIDTH; these drive the shared combinational ALU.
REQ-008 SHALL have ports: alu_result  input  WIDTH; alu_zero  input  1; these are the ALU outputs.
REQ-009 SHALL have ports: rsp0_valid / rsp1_valid  output  1; rsp0_ready / rsp1_ready  input  1; this is the response handshake.
REQ-010 SHALL have ports: rsp_result  output  WIDTH; rsp_zero  output  1; rsp_err  output  1; these form the response payload shared by both requesters.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-013 IDLE: when either reqN_valid is high, SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its op/a/b and grant id, and go to EXEC.
REQ-014 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; the last-grant pointer SHALL reset to 1, so req0 wins the first tie.
REQ-015 A single valid requester SHALL be granted regardless of the pointer.
REQ-016 reqN_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-017 alu_op/alu_a/alu_b SHALL always equal the latched registers; the latched registers SHALL update only on accept.
REQ-018 EXEC, one cycle: SHALL capture alu_result and alu_zero into response registers, then go to RESP.
REQ-019 Legal opcodes are 0000 add, 0100 sub, 0001 and, 0101 or, 0010 xor, 0110 pass-b; any other opcode SHALL set rsp_err=1, rsp_result=0 and rsp_zero=1; legal opcodes SHALL set rsp_err=0.
REQ-020 RESP: SHALL assert rspN_valid only for the granted id and hold the payload stable until rspN_ready is high.
REQ-021 On a RESP cycle with rspN_ready=1, SHALL deassert rspN_valid next cycle, update the last-grant pointer to N, and return to IDLE.
REQ-022 Latency: accept at cycle T -> rspN_valid high at T+2 -> earliest next accept at T+3.
REQ-023 rsp ready for the non-granted id SHALL be ignored; rspN_valid for both ids SHALL never be high simultaneously.
REQ-024 Request inputs changing while busy SHALL not affect the in-flight operation.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with no overflow flag.

Reset
REQ-026 rst high at a clock edge SHALL force state IDLE, pointer=1, and all latched op/operands, rsp_result, rsp_zero and rsp_err to 0.
REQ-027 During and after reset, busy, reqN_ready and rspN_valid SHALL be 0 until a new accept.
REQ-028 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Verification
REQ-029 After reset, req0 valid with op=0000, a=5, b=7 and rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2 with result=12, zero=0, err=0.
REQ-030 Both valid at each IDLE, four operations -> grants 0,1,0,1; no double response.
REQ-031 req1 op=0100, a=b=9 with rsp1_ready held low 5 cycles -> rsp1_valid and payload (0, zero=1) held stable 5 cycles, busy=1, req0_ready=0 throughout.
REQ-032 req0 op=1111 -> rsp0_valid with err=1, result=0, zero=1; pointer advances normally.
REQ-033 rst asserted in RESP -> next cycle rsp0_valid=0, busy=0, outputs zero; next tie granted to req0.
REQ-034 Check op=0110, a=1, b=0xFFFFFFFF -> result 0xFFFFFFFF; check 0xFFFFFFFF+1 -> result 0, zero=1.
